prog_clk_div_n: RTL and testbench

PROG_CLK_DIV_N -- requirements
Module: prog_clk_div_n

---
 rtl/prog_clk_div_n.sv | 82 ++++++++
 tb/tb_prog_clk_div_n.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_clk_div_n.sv
// prog_clk_div_n: programmable clock divider, 50% duty for any N >= 2, clkin bypass at N = 1.
// Defining PCD_SYNC_PULSE_EN adds a period_sync output pulsing one clkin period per clkdiv rise.
module prog_clk_div_n #(
   parameter int WIDTH       = 9,
   parameter int RESET_RATIO = 2
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] ratio_wdata,
   input  logic             ratio_wvalid,
   output logic             ratio_wready,
   output logic             ratio_err,
   output logic [WIDTH-1:0] cur_ratio,
`ifdef PCD_SYNC_PULSE_EN
   output logic             period_sync,
`endif
   output logic             clkdiv
);
   localparam logic [WIDTH-1:0] RR  = WIDTH'(RESET_RATIO);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   if (RESET_RATIO < 2 || RESET_RATIO > (2 ** WIDTH) - 1) begin : g_bad_reset_ratio
      $error("RESET_RATIO must lie in 2..2^WIDTH-1");
   end
   logic [WIDTH-1:0] cnt_q, cnt_d, cur_q, cur_d, pend_q, pend_d;
   logic             run_q, run_d, pend_v_q, pend_v_d, err_q, err_d, hi_q, hi_d;
   logic             neg_q, byp_q, byp_d, bnd, xfer, apply;
   always_comb begin
      bnd      = run_q && cnt_q == '0;
      xfer     = ratio_wvalid && !pend_v_q;
      apply    = bnd && pend_v_q;
      err_d    = xfer && ratio_wdata == '0;
      pend_v_d = (xfer && ratio_wdata != '0) || (pend_v_q && !apply);
      pend_d   = xfer ? ratio_wdata : pend_q;
      cur_d    = apply ? pend_q : cur_q;
      run_d    = bnd ? en : (run_q || en);
      cnt_d    = bnd ? cur_d - ONE : run_q ? cnt_q - ONE : en ? '0 : cnt_q;
      hi_d     = run_d && cnt_d >= cur_d - (cur_d >> 1);
      // bypass is decided on the falling edge, looking ahead at whether the next boundary leaves N = 1
      byp_d    = run_q && en && cur_q == ONE && !(pend_v_q && pend_q != ONE);
   end
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         cnt_q    <= RR - ONE;
         cur_q    <= RR;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         run_q    <= 1'b0;
         err_q    <= 1'b0;
         hi_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         cur_q    <= cur_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         run_q    <= run_d;
         err_q    <= err_d;
         hi_q     <= hi_d;
      end
   end
   always_ff @(negedge clkin or posedge rst) begin
      if (rst) begin
         neg_q <= 1'b0;
         byp_q <= 1'b0;
      end else begin
         neg_q <= hi_q;
         byp_q <= byp_d;
      end
   end
   assign ratio_wready = !pend_v_q;
   assign ratio_err    = err_q;
   assign cur_ratio    = cur_q;
   assign clkdiv       = byp_q ? clkin : (hi_q || (cur_q[0] && neg_q));
`ifdef PCD_SYNC_PULSE_EN
   logic sync_q;
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) sync_q <= 1'b0;
      else     sync_q <= bnd && en && (cur_d != ONE || byp_q);
   end
   assign period_sync = sync_q;
`endif
endmodule

// File: tb/tb_prog_clk_div_n.sv
// tb_prog_clk_div_n: directed ratio table plus hand sequences for start, idle and reset corners.
// Waveforms are measured in clkin half-periods, sampled 2 time units after every clkin edge.
module tb_prog_clk_div_n;
   logic       clkin = 1'b0, rst = 1'b1, en = 1'b0, ratio_wvalid = 1'b0;
   logic [8:0] ratio_wdata = '0;
   logic       ratio_wready, ratio_err, clkdiv;
   logic [8:0] cur_ratio;
`ifdef PCD_SYNC_PULSE_EN
   logic       period_sync;
`endif
   int         checks = 0, failures = 0;

   typedef struct {
      logic [8:0] wdata;
      logic       err;
      logic [8:0] cur;
      int         hi;
      int         per;
   } vec_t;
   vec_t       tbl [8];
   logic [8:0] cur_m;

   prog_clk_div_n dut (
      .clkin(clkin), .rst(rst), .en(en),
      .ratio_wdata(ratio_wdata), .ratio_wvalid(ratio_wvalid), .ratio_wready(ratio_wready),
      .ratio_err(ratio_err), .cur_ratio(cur_ratio),
`ifdef PCD_SYNC_PULSE_EN
      .period_sync(period_sync),
`endif
      .clkdiv(clkdiv)
   );

   always #5 clkin = ~clkin;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(clkin);
      #2;
   endtask

   task automatic cyc();
      @(posedge clkin);
      #2;
   endtask

   task automatic find_rise(input string name);
      logic prev;
      logic found;
      prev  = clkdiv;
      found = 1'b0;
      for (int i = 0; i < 2600 && !found; i++) begin
         step();
         found = !prev && clkdiv === 1'b1;
         prev  = clkdiv;
      end
      chk({name, "_rise_found"}, 32'(found), 1);
      chk({name, "_rise_in_clkin_high"}, 32'(clkin), 1);
   endtask

   // called on the sample just after a clkdiv rise; returns on the sample after the next rise
   task automatic measure(input string name, input int hi_exp, input int per_exp);
      int hi, per, sync;
      hi = 0;
      sync = 0;
      while (clkdiv === 1'b1 && hi < 2600) begin
`ifdef PCD_SYNC_PULSE_EN
         sync += int'(period_sync);
`endif
         step();
         hi++;
      end
      per = hi;
      while (clkdiv === 1'b0 && per < 5200) begin
`ifdef PCD_SYNC_PULSE_EN
         sync += int'(period_sync);
`endif
         step();
         per++;
      end
      chk({name, "_high_halves"}, 32'(hi), 32'(hi_exp));
      chk({name, "_period_halves"}, 32'(per), 32'(per_exp));
`ifdef PCD_SYNC_PULSE_EN
      chk({name, "_sync_halves"}, 32'(sync), 2);
`endif
   endtask

   initial begin
      int hi_cnt;
      tbl[0] = '{9'd6, 1'b0, 9'd6, 6, 12};
      tbl[1] = '{9'd7, 1'b0, 9'd7, 7, 14};
      tbl[2] = '{9'd0, 1'b1, 9'd7, 7, 14};
      tbl[3] = '{9'd3, 1'b0, 9'd3, 3, 6};
      tbl[4] = '{9'd2, 1'b0, 9'd2, 2, 4};
      tbl[5] = '{9'd1, 1'b0, 9'd1, 1, 2};
      tbl[6] = '{9'd4, 1'b0, 9'd4, 4, 8};
      tbl[7] = '{9'd5, 1'b0, 9'd5, 5, 10};
      cur_m = 9'd2;

      #12;
      chk("rst_clkdiv", 32'(clkdiv), 0);
      chk("rst_wready", 32'(ratio_wready), 1);
      chk("rst_err", 32'(ratio_err), 0);
      chk("rst_cur", 32'(cur_ratio), 2);
      @(negedge clkin);
      #2 rst = 1'b0;
      repeat (3) cyc();
      chk("idle_clkdiv", 32'(clkdiv), 0);
      en = 1'b1;
      cyc();
      chk("start_edge_low", 32'(clkdiv), 0);
      cyc();
      chk("start_rise", 32'(clkdiv), 1);
      chk("start_cur", 32'(cur_ratio), 2);
      step();
      chk("n2_high_negphase", 32'(clkdiv), 1);
      step();
      chk("n2_low", 32'(clkdiv), 0);
      step();
      chk("n2_low_negphase", 32'(clkdiv), 0);
      step();
      chk("n2_rise_again", 32'(clkdiv), 1);

      for (int i = 0; i < 8; i++) begin
         ratio_wdata  = tbl[i].wdata;
         ratio_wvalid = 1'b1;
         cyc();
         ratio_wvalid = 1'b0;
         chk($sformatf("v%0d_err", i), 32'(ratio_err), 32'(tbl[i].err));
         chk($sformatf("v%0d_wready", i), 32'(ratio_wready), 32'(tbl[i].err));
         chk($sformatf("v%0d_cur_held", i), 32'(cur_ratio), 32'(cur_m));
         if (tbl[i].err) begin
            cyc();
            chk($sformatf("v%0d_err_one_cycle", i), 32'(ratio_err), 0);
            chk($sformatf("v%0d_wready_after_err", i), 32'(ratio_wready), 1);
         end
         find_rise($sformatf("v%0d", i));
         chk($sformatf("v%0d_cur_applied", i), 32'(cur_ratio), 32'(tbl[i].cur));
         measure($sformatf("v%0d", i), tbl[i].hi, tbl[i].per);
         cur_m = tbl[i].cur;
      end

      // N=5: drop en just after a rise; the period finishes, then clkdiv stays low
      en = 1'b0;
      hi_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         hi_cnt += int'(clkdiv);
         step();
      end
      chk("endrop_high_halves", 32'(hi_cnt), 5);
      ratio_wdata  = 9'd3;
      ratio_wvalid = 1'b1;
      cyc();
      ratio_wvalid = 1'b0;
      repeat (3) cyc();
      chk("idle_pending_wready", 32'(ratio_wready), 0);
      chk("idle_pending_cur", 32'(cur_ratio), 5);
      chk("idle_clkdiv_low", 32'(clkdiv), 0);
      en = 1'b1;
      cyc();
      chk("restart_edge_low", 32'(clkdiv), 0);
      chk("restart_edge_cur", 32'(cur_ratio), 5);
      cyc();
      chk("restart_rise", 32'(clkdiv), 1);
      chk("restart_cur", 32'(cur_ratio), 3);
      chk("restart_wready", 32'(ratio_wready), 1);
      measure("restart", 3, 6);

      // N=511: reset in the middle of the high phase with a ratio pending
      ratio_wdata  = 9'd511;
      ratio_wvalid = 1'b1;
      cyc();
      ratio_wvalid = 1'b0;
      find_rise("n511");
      chk("n511_cur", 32'(cur_ratio), 511);
      repeat (20) step();
      ratio_wdata  = 9'd6;
      ratio_wvalid = 1'b1;
      cyc();
      ratio_wvalid = 1'b0;
      chk("n511_pending_wready", 32'(ratio_wready), 0);
      chk("n511_high", 32'(clkdiv), 1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_clkdiv", 32'(clkdiv), 0);
      chk("midrst_cur", 32'(cur_ratio), 2);
      chk("midrst_wready", 32'(ratio_wready), 1);
      chk("midrst_err", 32'(ratio_err), 0);
      @(negedge clkin);
      #2 rst = 1'b0;
      find_rise("postrst");
      chk("postrst_cur", 32'(cur_ratio), 2);
      chk("postrst_wready", 32'(ratio_wready), 1);
      measure("postrst", 2, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
